// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared RV32I register-file types, also used by registerR32I and the decoder.
package regfile_wb_scheduler_pkg;
  localparam int NumRegs = 32;
  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] regdata_t;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bus: NumSrc sources with packed address/data lanes (i=0 in LSBs).
interface regfile_wb_scheduler_if #(
  parameter int NumSrc = 3,
  parameter int AddrW  = 5,
  parameter int dataW  = 32
);
  logic [NumSrc-1:0]       WbValid;
  logic [NumSrc*AddrW-1:0] WbAddr;
  logic [NumSrc*dataW-1:0] WbData;
  logic [NumSrc-1:0]       WbReady;

  modport master (output WbValid, WbAddr, WbData, input WbReady);
  modport slave  (input WbValid, WbAddr, WbData, output WbReady);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves past the winner only when the caller signals the grant was taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] r_ptr;
  logic [PtrW-1:0] w_next;

  // Rotating priority search starting at r_ptr, wrapping N-1 -> 0
  always_comb begin
    logic        found;
    int unsigned idx;
    gnt    = '0;
    w_next = r_ptr;
    found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        w_next   = (idx == N - 1) ? '0 : PtrW'(idx + 1);
      end
    end
  end

  // Pointer register: holds when nothing is granted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_ptr <= '0;
    else if (advance) r_ptr <= w_next;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the regfile write port between writeback sources and tracks in-flight
// destinations in a busy-bit scoreboard for RAW hazard stalls.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int dataW  = 32,
  parameter int NumSrc = 3,
  parameter int AddrW  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_wb_scheduler_if.slave wb,
  output logic                  RegWriteControl,
  output logic [AddrW-1:0]      RegWriteAddr,
  output logic [dataW-1:0]      RegDataIn,
  input  logic                  AllocValid,
  input  logic [AddrW-1:0]      AllocAddr,
  output logic                  AllocError,
  input  logic [AddrW-1:0]      QueryAddr1,
  input  logic [AddrW-1:0]      QueryAddr2,
  output logic                  Busy1,
  output logic                  Busy2
);
  localparam int NumBusy = 1 << AddrW;

  logic [NumSrc-1:0]  w_gnt;
  logic [NumSrc-1:0]  w_ready;
  logic               w_grant;
  logic [AddrW-1:0]   w_sel_addr;
  logic [dataW-1:0]   w_sel_data;
  logic               r_we;
  logic [AddrW-1:0]   r_addr;
  logic [dataW-1:0]   r_data;
  logic               r_alloc_err;
  logic [NumBusy-1:0] r_busy;
  logic [NumBusy-1:0] w_busy_next;
  logic               w_alloc_nz;
  logic               w_clr_hit;
  logic               w_alloc_ok;

  rr_arbiter #(.N(NumSrc)) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (wb.WbValid),
    .advance (w_grant),
    .gnt     (w_gnt)
  );

  // Grants are suppressed while reset is held so no source sees a false transfer
  assign w_ready    = w_gnt & {NumSrc{reset}};
  assign wb.WbReady = w_ready;
  assign w_grant    = |w_ready;

  // One-hot mux of the winning source's address and data
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NumSrc; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr | wb.WbAddr[i*AddrW +: AddrW];
        w_sel_data = w_sel_data | wb.WbData[i*dataW +: dataW];
      end
    end
  end

  // Registered write port: one-cycle enable pulse, x0 writes consumed silently
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_grant) begin
      r_we   <= (w_sel_addr != '0);
      r_addr <= w_sel_addr;
      r_data <= w_sel_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  // Next scoreboard state: clear on regfile capture, then set, so set wins on a tie
  always_comb begin
    w_alloc_nz  = AllocValid && (AllocAddr != '0);
    w_clr_hit   = r_we && (r_addr == AllocAddr);
    w_alloc_ok  = w_alloc_nz && (!r_busy[AllocAddr] || w_clr_hit);
    w_busy_next = r_busy;
    if (r_we)       w_busy_next[r_addr]    = 1'b0;
    if (w_alloc_ok) w_busy_next[AllocAddr] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard and single-cycle allocation error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy      <= '0;
      r_alloc_err <= 1'b0;
    end else begin
      r_busy      <= w_busy_next;
      r_alloc_err <= w_alloc_nz && !w_alloc_ok;
    end
  end

  assign RegWriteControl = r_we;
  assign RegWriteAddr    = r_addr;
  assign RegDataIn       = r_data;
  assign AllocError      = r_alloc_err;
  assign Busy1           = r_busy[QueryAddr1];
  assign Busy2           = r_busy[QueryAddr2];
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset, handshake, fairness, scoreboard.
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic           clock;
  logic           reset;
  logic           RegWriteControl;
  regaddr_t       RegWriteAddr;
  regdata_t       RegDataIn;
  logic           AllocValid;
  regaddr_t       AllocAddr;
  logic           AllocError;
  regaddr_t       QueryAddr1;
  regaddr_t       QueryAddr2;
  logic           Busy1;
  logic           Busy2;

  int n_checks;
  int n_fail;

  regfile_wb_scheduler_if #(.NumSrc(NS), .AddrW(AW), .dataW(DW)) wb_if ();

  regfile_wb_scheduler #(.dataW(DW), .NumSrc(NS), .AddrW(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .wb              (wb_if),
    .RegWriteControl (RegWriteControl),
    .RegWriteAddr    (RegWriteAddr),
    .RegDataIn       (RegDataIn),
    .AllocValid      (AllocValid),
    .AllocAddr       (AllocAddr),
    .AllocError      (AllocError),
    .QueryAddr1      (QueryAddr1),
    .QueryAddr2      (QueryAddr2),
    .Busy1           (Busy1),
    .Busy2           (Busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_if.WbAddr[i*AW +: AW] = a;
    wb_if.WbData[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wb_if.WbValid = '0; wb_if.WbAddr = '0; wb_if.WbData = '0;
    AllocValid = 1'b0; AllocAddr = '0; QueryAddr1 = '0; QueryAddr2 = '0;
    #2;
    reset = 1'b1;
    wb_if.WbValid = 3'b111;
    set_src(0, 5'd7, 32'd70); set_src(1, 5'd8, 32'd80); set_src(2, 5'd9, 32'd90);
    AllocValid = 1'b1; AllocAddr = 5'd5; QueryAddr1 = 5'd5;
    #6; // t=8, after edge at 5
    n_checks++; if (RegWriteControl !== 1'b1 || RegWriteAddr !== 5'd7) begin n_fail++;
      $display("FAIL pre_reset_write: we=%b addr=%0d expected we=1 addr=7", RegWriteControl, RegWriteAddr); end
    n_checks++; if (Busy1 !== 1'b1) begin n_fail++;
      $display("FAIL pre_reset_busy: got %b expected 1", Busy1); end
    #2; // t=10
    reset = 1'b0;
    #1;
    n_checks++; if (RegWriteControl !== 1'b0 || RegWriteAddr !== '0 || RegDataIn !== '0) begin n_fail++;
      $display("FAIL reset_port: we=%b addr=%0d data=%0d expected 0/0/0", RegWriteControl, RegWriteAddr, RegDataIn); end
    n_checks++; if (AllocError !== 1'b0 || Busy1 !== 1'b0 || Busy2 !== 1'b0) begin n_fail++;
      $display("FAIL reset_sb: err=%b busy1=%b busy2=%b expected 0/0/0", AllocError, Busy1, Busy2); end
    n_checks++; if (wb_if.WbReady !== 3'b000) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 000", wb_if.WbReady); end
    #1; // t=12
    wb_if.WbValid = '0; AllocValid = 1'b0; QueryAddr1 = '0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    wb_if.WbValid = 3'b010;
    set_src(1, 5'd3, 32'd897);
    #1;
    n_checks++; if (wb_if.WbReady !== 3'b010) begin n_fail++;
      $display("FAIL single_ready: got %b expected 010", wb_if.WbReady); end
    step();
    wb_if.WbValid = '0;
    n_checks++; if (RegWriteControl !== 1'b1 || RegWriteAddr !== 5'd3 || RegDataIn !== 32'd897) begin n_fail++;
      $display("FAIL single_write: we=%b addr=%0d data=%0d expected 1/3/897", RegWriteControl, RegWriteAddr, RegDataIn); end
    step();
    n_checks++; if (RegWriteControl !== 1'b0 || RegWriteAddr !== 5'd3) begin n_fail++;
      $display("FAIL single_drop: we=%b addr=%0d expected 0/3", RegWriteControl, RegWriteAddr); end
  endtask

  task automatic test_round_robin();
    logic [NS-1:0] exp_g [4];
    logic [AW-1:0] exp_a [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_a[0] = 5'd4;   exp_a[1] = 5'd5;   exp_a[2] = 5'd6;   exp_a[3] = 5'd4;
    // pointer is at 2 after the single grant to src1; one src2 grant wraps it to 0
    wb_if.WbValid = 3'b100;
    set_src(0, 5'd4, 32'd10); set_src(1, 5'd5, 32'd11); set_src(2, 5'd6, 32'd12);
    #1;
    n_checks++; if (wb_if.WbReady !== 3'b100) begin n_fail++;
      $display("FAIL rr_wrap: got %b expected 100", wb_if.WbReady); end
    step();
    wb_if.WbValid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (wb_if.WbReady !== exp_g[c]) begin n_fail++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", c, wb_if.WbReady, exp_g[c]); end
      step();
      n_checks++; if (RegWriteControl !== 1'b1 || RegWriteAddr !== exp_a[c]) begin n_fail++;
        $display("FAIL rr_write[%0d]: we=%b addr=%0d expected 1/%0d", c, RegWriteControl, RegWriteAddr, exp_a[c]); end
    end
    wb_if.WbValid = '0;
  endtask

  task automatic test_scoreboard();
    AllocValid = 1'b1; AllocAddr = 5'd2; QueryAddr1 = 5'd2; QueryAddr2 = 5'd0;
    #1;
    n_checks++; if (Busy1 !== 1'b0) begin n_fail++;
      $display("FAIL sb_pre: got %b expected 0", Busy1); end
    step();
    AllocValid = 1'b0;
    n_checks++; if (Busy1 !== 1'b1 || Busy2 !== 1'b0 || AllocError !== 1'b0) begin n_fail++;
      $display("FAIL sb_set: busy1=%b busy2=%b err=%b expected 1/0/0", Busy1, Busy2, AllocError); end
    wb_if.WbValid = 3'b001;
    set_src(0, 5'd2, 32'd666);
    #1;
    n_checks++; if (wb_if.WbReady !== 3'b001) begin n_fail++;
      $display("FAIL sb_ready: got %b expected 001", wb_if.WbReady); end
    step();
    wb_if.WbValid = '0;
    n_checks++; if (RegWriteControl !== 1'b1 || RegWriteAddr !== 5'd2 || RegDataIn !== 32'd666 || Busy1 !== 1'b1) begin n_fail++;
      $display("FAIL sb_write: we=%b addr=%0d data=%0d busy1=%b expected 1/2/666/1", RegWriteControl, RegWriteAddr, RegDataIn, Busy1); end
    step();
    n_checks++; if (Busy1 !== 1'b0 || RegWriteControl !== 1'b0) begin n_fail++;
      $display("FAIL sb_clear: busy1=%b we=%b expected 0/0", Busy1, RegWriteControl); end
  endtask

  task automatic test_set_clear_tie();
    AllocValid = 1'b1; AllocAddr = 5'd2;
    step();
    AllocValid = 1'b0;
    n_checks++; if (Busy1 !== 1'b1) begin n_fail++;
      $display("FAIL tie_setup: got %b expected 1", Busy1); end
    wb_if.WbValid = 3'b001;
    set_src(0, 5'd2, 32'd7);
    step();
    wb_if.WbValid = '0;
    AllocValid = 1'b1; AllocAddr = 5'd2;
    n_checks++; if (RegWriteControl !== 1'b1 || RegWriteAddr !== 5'd2) begin n_fail++;
      $display("FAIL tie_write: we=%b addr=%0d expected 1/2", RegWriteControl, RegWriteAddr); end
    step();
    n_checks++; if (Busy1 !== 1'b1 || AllocError !== 1'b0) begin n_fail++;
      $display("FAIL tie_set_wins: busy1=%b err=%b expected 1/0", Busy1, AllocError); end
    step();
    AllocValid = 1'b0;
    n_checks++; if (AllocError !== 1'b1) begin n_fail++;
      $display("FAIL dup_alloc_err: got %b expected 1", AllocError); end
    step();
    n_checks++; if (AllocError !== 1'b0 || Busy1 !== 1'b1) begin n_fail++;
      $display("FAIL dup_alloc_pulse: err=%b busy1=%b expected 0/1", AllocError, Busy1); end
  endtask

  task automatic test_x0();
    wb_if.WbValid = 3'b100;
    set_src(2, 5'd0, 32'd5);
    AllocValid = 1'b1; AllocAddr = 5'd0; QueryAddr1 = 5'd0; QueryAddr2 = 5'd3;
    #1;
    n_checks++; if (wb_if.WbReady !== 3'b100) begin n_fail++;
      $display("FAIL x0_ready: got %b expected 100", wb_if.WbReady); end
    step();
    wb_if.WbValid = '0; AllocValid = 1'b0;
    n_checks++; if (RegWriteControl !== 1'b0 || AllocError !== 1'b0) begin n_fail++;
      $display("FAIL x0_write: we=%b err=%b expected 0/0", RegWriteControl, AllocError); end
    n_checks++; if (Busy1 !== 1'b0 || Busy2 !== 1'b0) begin n_fail++;
      $display("FAIL x0_busy: busy1=%b busy2=%b expected 0/0", Busy1, Busy2); end
    step();
    n_checks++; if (RegWriteControl !== 1'b0 || AllocError !== 1'b0) begin n_fail++;
      $display("FAIL x0_after: we=%b err=%b expected 0/0", RegWriteControl, AllocError); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_set_clear_tie();
    test_x0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
